// File: rtl/ctl_charlieplex_scroll_pkg.sv
// Shared constants and types for the charlieplex scroller and the display peripheral it feeds.
package ctl_charlieplex_scroll_pkg;

  localparam int unsigned Rows = 5;
  localparam int unsigned Cols = 7;
  localparam int unsigned RowW = 3;
  localparam int unsigned AdrW = 4;
  localparam int unsigned DatW = 8;

  typedef enum logic {StIdle, StWrite} state_e;

  typedef logic [Cols-1:0] row_t;

  // Row register format: bit 7 unused, bits 6..0 are the columns of that row.
  function automatic logic [DatW-1:0] row_dat(row_t r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/ctl_charlieplex_scroll_if.sv
// Wishbone B4 write-only bus between the scroller (master) and the display peripheral (slave).
interface ctl_charlieplex_scroll_if;
  import ctl_charlieplex_scroll_pkg::*;

  logic            cyc;
  logic            stb;
  logic            we;
  logic [AdrW-1:0] adr;
  logic [DatW-1:0] dat;
  logic            ack;

  modport master (output cyc, stb, we, adr, dat, input ack);
  modport slave  (input cyc, stb, we, adr, dat, output ack);

endinterface

// File: rtl/ctl_charlieplex_scroll_tick_divider.sv
// Free-running divider: one-cycle tick every ClkHz/TickHz cycles, on the counter wrap.
module ctl_charlieplex_scroll_tick_divider #(
  parameter int unsigned ClkHz  = 0,
  parameter int unsigned TickHz = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned Period = ClkHz / TickHz;
  localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;
  localparam logic [CntW-1:0] Last = CntW'(Period - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == Last);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ctl_charlieplex_scroll.sv
// Scrolls a 5x7 pixel window one column per tick and rewrites all five display row
// registers over Wishbone after every step.
module ctl_charlieplex_scroll
  import ctl_charlieplex_scroll_pkg::*;
#(
  parameter int unsigned ClkHz    = 0,
  parameter int unsigned ScrollHz = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [Rows-1:0]           s_data_i,
  input  logic                      s_valid_i,
  output logic                      s_ready_o,
  ctl_charlieplex_scroll_if.master  wb,
  output logic                      busy_o
);

  state_e                      state_q, state_d;
  logic [RowW-1:0]             row_q, row_d;
  logic [Rows-1:0][Cols-1:0]   win_q, win_d;
  logic                        pending_q, pending_d;
  logic                        stb_q, stb_d;
  logic [AdrW-1:0]             adr_q, adr_d;
  logic [DatW-1:0]             dat_q, dat_d;
  logic                        tick;
  logic                        step;
  logic [Rows-1:0]             col;

  ctl_charlieplex_scroll_tick_divider #(
    .ClkHz  (ClkHz),
    .TickHz (ScrollHz)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick)
  );

  // Gated by reset so no column is ever consumed while reset is asserted.
  assign s_ready_o = rst_ni & (state_q == StIdle) & pending_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    win_d   = win_q;
    step    = 1'b0;
    col     = '0;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          step = 1'b1;
          col  = s_valid_i ? s_data_i : '0;
          for (int r = 0; r < Rows; r++) begin
            win_d[r] = {col[r], win_q[r][Cols-1:1]};
          end
          row_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        // stb_q guards the reset-release cycle, where the bus is not yet driven.
        if (stb_q && wb.ack) begin
          if (row_q == RowW'(Rows - 1)) begin
            state_d = StIdle;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
    endcase
    // A tick coinciding with a step re-arms pending rather than being lost.
    pending_d = tick | (pending_q & ~step);
    stb_d     = (state_d == StWrite);
    adr_d     = {1'b0, row_d};
    dat_d     = row_dat(win_d[row_d]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StWrite;
      row_q     <= '0;
      win_q     <= '0;
      pending_q <= 1'b0;
      stb_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      win_q     <= win_d;
      pending_q <= pending_d;
      stb_q     <= stb_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
    end
  end

  assign wb.cyc = stb_q;
  assign wb.stb = stb_q;
  assign wb.we  = stb_q;
  assign wb.adr = adr_q;
  assign wb.dat = dat_q;
  assign busy_o = stb_q;

endmodule

// File: tb/tb_ctl_charlieplex_scroll.sv
// Randomised bench for ctl_charlieplex_scroll against a column-array reference model.
module tb_ctl_charlieplex_scroll;
  import ctl_charlieplex_scroll_pkg::*;

  localparam int unsigned ClkHz    = 160;
  localparam int unsigned ScrollHz = 10;
  localparam int          P        = 16;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [4:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       busy;

  logic ack_en = 1'b1;
  logic rand_wait = 1'b0;
  int   fix_wait = 0;
  int   rnd_wait = 0;
  int   wait_cnt = 0;

  int n_checks = 0;
  int n_fail = 0;

  ctl_charlieplex_scroll_if wb_bus ();

  ctl_charlieplex_scroll #(
    .ClkHz    (ClkHz),
    .ScrollHz (ScrollHz)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .s_data_i  (s_data),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .wb        (wb_bus),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  // Slave: ack once stb has been held for the selected number of wait states.
  assign wb_bus.ack = ack_en && wb_bus.stb &&
                      (wait_cnt >= (rand_wait ? rnd_wait : fix_wait));

  always @(posedge clk) begin
    if (wb_bus.stb && !wb_bus.ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (wb_bus.ack) rnd_wait <= int'($urandom_range(3, 0));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: window kept as 7 columns, index 6 newest.
  logic [4:0] m_col [7];
  int         m_cnt, m_beat;
  bit         m_in_frame, m_launch, m_pend, m_live;

  function automatic logic [7:0] m_row(int r);
    logic [7:0] res;
    res = '0;
    for (int c = 0; c < 7; c++) res[c] = m_col[c][r];
    return res;
  endfunction

  always @(negedge clk) begin : model
    bit tick, step, exp_ready;
    exp_ready = rst_ni && m_live && !m_in_frame && !m_launch && m_pend;
    if (m_live) begin
      check_eq("s_ready", 32'(s_ready), 32'(exp_ready));
      check_eq("stb", 32'(wb_bus.stb), 32'(m_in_frame));
      check_eq("cyc", 32'(wb_bus.cyc), 32'(m_in_frame));
      check_eq("busy", 32'(busy), 32'(m_in_frame));
      if (m_in_frame) begin
        check_eq("we", 32'(wb_bus.we), 32'd1);
        check_eq("adr", 32'(wb_bus.adr), 32'(m_beat));
        check_eq("dat", 32'(wb_bus.dat), 32'(m_row(m_beat)));
      end
    end
    if (!rst_ni) begin
      for (int c = 0; c < 7; c++) m_col[c] = '0;
      m_cnt = 0; m_beat = 0; m_pend = 0;
      m_in_frame = 0; m_launch = 1; m_live = 1;
    end else if (m_live) begin
      tick  = (m_cnt == P - 1);
      m_cnt = (m_cnt + 1) % P;
      step  = exp_ready;
      if (m_launch) begin
        m_in_frame = 1; m_beat = 0; m_launch = 0;
      end else if (m_in_frame) begin
        if (wb_bus.ack) begin
          if (m_beat == 4) m_in_frame = 0;
          else m_beat++;
        end
      end else if (step) begin
        for (int c = 0; c < 6; c++) m_col[c] = m_col[c+1];
        m_col[6] = s_valid ? s_data : 5'b0;
        m_in_frame = 1; m_beat = 0;
      end
      m_pend = tick || (m_pend && !step);
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_rand(input int n, input int pct);
    repeat (n) begin
      @(posedge clk);
      #1;
      s_valid = ($urandom_range(99, 0) < pct);
      s_data  = 5'($urandom);
    end
  endtask

  initial begin
    bit found;
    // Reset, then the blank frame.
    run(3);
    rst_ni = 1'b1;
    run(20);
    // Full columns streamed in.
    s_valid = 1'b1; s_data = 5'h1F;
    run(8 * P + 10);
    // Single-row column, then stream dries up.
    s_data = 5'h01;
    run(7 * P);
    s_valid = 1'b0;
    run(8 * P);
    // Three wait states per beat, frame longer than the tick period.
    fix_wait = 3;
    run_rand(8 * P, 70);
    // Ack held low across several ticks.
    fix_wait = 0;
    s_valid = 1'b1; s_data = 5'h15;
    found = 0;
    for (int i = 0; i < 4 * P && !found; i++) begin
      @(posedge clk); #1;
      found = (wb_bus.stb === 1'b1);
    end
    check_eq("wait_frame", 32'(found), 32'd1);
    ack_en = 1'b0;
    run(3 * P);
    ack_en = 1'b1;
    run(3 * P);
    // Random waits, then a reset in the middle of row 2.
    rand_wait = 1'b1;
    run_rand(4 * P, 60);
    found = 0;
    for (int i = 0; i < 12 * P && !found; i++) begin
      @(posedge clk); #1;
      found = m_in_frame && (m_beat == 2);
    end
    check_eq("wait_row2", 32'(found), 32'd1);
    rst_ni = 1'b0;
    run(1);
    rst_ni = 1'b1;
    run_rand(10 * P, 60);
    rand_wait = 1'b0;
    run_rand(4 * P, 50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
